seq_add16_flags: RTL and testbench

- Multi-cycle 16-bit add/subtract unit with an ALU-style flag output.
- Built from the team's half/full-adder cells: one CHUNK-bit ripple slice is reused over WIDTH/CHUNK cycles, with the inter-slice carry held in a register.
- Accepts operands over a valid/ready handshake and returns sum plus flags over a second valid/ready handshake.
- Sits between the operand-issue logic and the result/flag register file.

---
 rtl/seq_add16_flags.sv | 213 +++++++++++++++++++++
 tb/tb_seq_add16_flags.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_add16_flags.sv
// Multi-cycle add/subtract unit: one CHUNK-bit ripple slice of full-adder cells
// is reused over WIDTH/CHUNK cycles, with the inter-slice carry held in a register.

module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1;
    logic c1;
    logic c2;

    ha_cell u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
    ha_cell u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

    assign co = c1 | c2;
endmodule

module ripple_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    logic [N:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < N; i++) begin : g_bit
        fa_cell u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
    end

    assign co = c[N];
endmodule

module seq_add16_flags #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             busy
);
    localparam int NSLICE = WIDTH / CHUNK;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB    = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   a_r_q,       a_r_d;
    logic [WIDTH-1:0]   b_r_q,       b_r_d;
    logic               carry_q,     carry_d;
    logic               sub_r_q,     sub_r_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [WIDTH-1:0]   sum_r_q,     sum_r_d;
    logic [WIDTH-1:0]   sum_q,       sum_d;
    logic               flag_c_q,    flag_c_d;
    logic               flag_z_q,    flag_z_d;
    logic               flag_n_q,    flag_n_d;
    logic               flag_v_q,    flag_v_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;

    logic [CHUNK-1:0]   slice_a;
    logic [CHUNK-1:0]   slice_b;
    logic [CHUNK-1:0]   slice_s;
    logic               slice_co;

    assign slice_a = a_r_q[idx_q*CHUNK +: CHUNK];
    assign slice_b = b_r_q[idx_q*CHUNK +: CHUNK];

    ripple_slice #(.N(CHUNK)) u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d  = state_q;
        a_r_d    = a_r_q;
        b_r_d    = b_r_q;
        carry_d  = carry_q;
        sub_r_d  = sub_r_q;
        idx_d    = idx_q;
        sum_r_d  = sum_r_q;
        sum_d    = sum_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        flag_v_d = flag_v_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Subtraction runs as A + ~B + ~borrow through the same adder.
                    a_r_d   = a;
                    b_r_d   = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    sub_r_d = sub;
                    idx_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                sum_r_d[idx_q*CHUNK +: CHUNK] = slice_s;
                carry_d = slice_co;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NSLICE - 1)) begin
                    idx_d    = '0;
                    sum_d    = sum_r_d;
                    flag_c_d = slice_co ^ sub_r_q;
                    flag_z_d = (sum_r_d == '0);
                    flag_n_d = sum_r_d[MSB];
                    flag_v_d = (a_r_q[MSB] == b_r_q[MSB]) && (sum_r_d[MSB] != a_r_q[MSB]);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_r_q       <= '0;
            b_r_q       <= '0;
            carry_q     <= 1'b0;
            sub_r_q     <= 1'b0;
            idx_q       <= '0;
            sum_r_q     <= '0;
            sum_q       <= '0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_r_q       <= a_r_d;
            b_r_q       <= b_r_d;
            carry_q     <= carry_d;
            sub_r_q     <= sub_r_d;
            idx_q       <= idx_d;
            sum_r_q     <= sum_r_d;
            sum_q       <= sum_d;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            flag_v_q    <= flag_v_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_v    = flag_v_q;
endmodule

// File: tb/tb_seq_add16_flags.sv
// Bench for seq_add16_flags: directed corner cases, backpressure, mid-operation
// reset and randomized traffic checked against an integer-arithmetic model.

module tb_seq_add16_flags;
    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         flag_c;
    logic         flag_z;
    logic         flag_n;
    logic         flag_v;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    // Expected entries packed as {c, z, n, v, sum}.
    logic [W+3:0] exp_q[$];

    seq_add16_flags #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v),
        .busy      (busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic, signed range test for overflow.
    function automatic logic [W+3:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        int ua = int'(ma);
        int ub = int'(mb);
        int sa = int'($signed(ma));
        int sb = int'($signed(mb));
        int ci = mcin ? 1 : 0;
        int r;
        int sr;
        logic c;
        logic v;
        logic [W-1:0] s;
        if (!msub) begin
            r  = ua + ub + ci;
            sr = sa + sb + ci;
            c  = (r > 65535);
        end else begin
            r  = ua - ub - ci;
            sr = sa - sb - ci;
            c  = (r < 0);
        end
        s = W'(r);
        v = (sr > 32767) || (sr < -32768);
        return {c, (s == '0), s[W-1], v, s};
    endfunction

    // Drivers
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tcin, input logic tsub);
        a        = ta;
        b        = tb_;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        exp_q.push_back(model(ta, tb_, tcin, tsub));
    endtask

    task automatic accept_and_wait();
        int lat;
        @(posedge clk);
        #1;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_in_ready", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            // Scrambled operands and a stray in_valid must not disturb the result.
            a        = W'($urandom);
            b        = W'($urandom);
            cin      = 1'($urandom);
            sub      = 1'($urandom);
            in_valid = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), 32'd4);
    endtask

    task automatic finish_result(input int hold);
        logic [W-1:0] s0;
        logic [3:0]   f0;
        logic [W+3:0] e;
        s0 = sum;
        f0 = {flag_c, flag_z, flag_n, flag_v};
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_sum", 32'(sum), 32'(s0));
            check("hold_flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'(f0));
        end
        if (exp_q.size() == 0) begin
            check("exp_queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("sum", 32'(sum), 32'(e[W-1:0]));
            check("flags_czn_v", 32'({flag_c, flag_z, flag_n, flag_v}), 32'(e[W+3:W]));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("handoff_out_valid", 32'(out_valid), 32'd0);
        check("handoff_in_ready", 32'(in_ready), 32'd1);
        check("handoff_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tcin, input logic tsub, input int hold);
        start_op(ta, tb_, tcin, tsub);
        accept_and_wait();
        finish_result(hold);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed corner cases
        run_op(16'h0001, 16'hFFFF, 1'b0, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 2);
        run_op(16'h0FFF, 16'h0000, 1'b1, 1'b0, 0);

        // Backpressure with a second bundle offered while the first is held.
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        accept_and_wait();
        start_op(16'hA5A5, 16'h0F0F, 1'b1, 1'b1);
        finish_result(5);
        accept_and_wait();
        finish_result(0);

        // Abort mid-calculation; the previous result (nonzero) must vanish.
        start_op(16'h4444, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_result", 32'(out_valid), 32'd0);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            run_op(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
